stmm_seq: RTL and testbench

Row sequencer for the static matrix-multiply engine (StMM). Accepts one layer command (row count, X/Y buffer base addresses, quantisation parameters), then streams X rows from the X buffer into StMM, pulses its start, waits for its result, and writes each Y row to the Y buffer. The next X row is prefetched while StMM computes. Sits between the NPU top-level command decoder and one StMM instance plus its X/Y buffers.

---
 rtl/tinynpu_stmm_pkg.sv | 33 +++
 rtl/stmm_seq_perf_cnt.sv | 32 +++
 rtl/stmm_seq.sv | 182 ++++++++++++++++++
 tb/tb_stmm_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tinynpu_stmm_pkg.sv
// Shared StMM types and constants: sequencer state encoding, layer command payload, default geometry.
package tinynpu_stmm_pkg;

  localparam int unsigned STMM_N = 176;
  localparam int unsigned STMM_P = 704;
  localparam int unsigned STMM_Q = 8;
  localparam int unsigned M_MAX  = 64;
  localparam int unsigned XAW    = 10;
  localparam int unsigned YAW    = 10;
  localparam int unsigned ROWS_W = $clog2(M_MAX + 1);
  localparam int unsigned PERF_W = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_XREQ  = 3'd1,
    S_XWAIT = 3'd2,
    S_START = 3'd3,
    S_RUN   = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } stmm_seq_state_t;

  typedef struct packed {
    logic [ROWS_W-1:0] rows;
    logic [XAW-1:0]    x_base;
    logic [YAW-1:0]    y_base;
    logic [15:0]       scale;
    logic [7:0]        z_x;
    logic [7:0]        z_w;
    logic [7:0]        zero;
  } stmm_cmd_t;

endpackage

// File: rtl/stmm_seq_perf_cnt.sv
// Saturating busy-cycle counter; cleared on command accept, holds when idle.
module stmm_seq_perf_cnt
  import tinynpu_stmm_pkg::*;
#(
  parameter int unsigned W = PERF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/stmm_seq.sv
// StMM row sequencer: fetch X row, start StMM, write Y row, prefetching the next X row during compute.
// Optional perf_cycles busy counter under `STMM_SEQ_PERF_EN.
module stmm_seq
  import tinynpu_stmm_pkg::*;
#(
  parameter int unsigned N = STMM_N,
  parameter int unsigned P = STMM_P,
  parameter int unsigned Q = STMM_Q
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ROWS_W-1:0] cmd_rows,
  input  logic [XAW-1:0]    cmd_x_base,
  input  logic [YAW-1:0]    cmd_y_base,
  input  logic [15:0]       cmd_scale_fp16,
  input  logic [7:0]        cmd_z_x,
  input  logic [7:0]        cmd_z_w,
  input  logic [7:0]        cmd_zero,
  output logic              x_rd_en,
  output logic [XAW-1:0]    x_rd_addr,
  input  logic [Q*N-1:0]    x_rd_data,
  output logic [Q*N-1:0]    mm_x,
  output logic              mm_start,
  output logic [15:0]       mm_scale_fp16,
  output logic [7:0]        mm_z_x,
  output logic [7:0]        mm_z_w,
  output logic [7:0]        mm_zero,
  input  logic [Q*P-1:0]    mm_y,
  input  logic              mm_out_valid,
  output logic              y_wr_en,
  output logic [YAW-1:0]    y_wr_addr,
  output logic [Q*P-1:0]    y_wr_data,
  output logic              busy,
`ifdef STMM_SEQ_PERF_EN
  output logic              done,
  output logic [PERF_W-1:0] perf_cycles
`else
  output logic              done
`endif
);

  stmm_seq_state_t   state_q, state_d;
  stmm_cmd_t         cmd_q, cmd_d;
  logic [ROWS_W-1:0] r_q, r_d;
  logic              accept;

  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              x_rd_en_q, x_rd_en_d;
  logic [XAW-1:0]    x_rd_addr_q, x_rd_addr_d;
  logic              cap_q, cap_d;
  logic [Q*N-1:0]    mm_x_q, mm_x_d;
  logic              mm_start_q, mm_start_d;
  logic              y_wr_en_q, y_wr_en_d;
  logic [YAW-1:0]    y_wr_addr_q, y_wr_addr_d;

  assign accept = (state_q == S_IDLE) && cmd_valid;

  // State, command and row-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      r_q     <= r_d;
    end
  end

  // Next state, command latch and row counter.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    r_d     = r_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_d   = '{rows: cmd_rows, x_base: cmd_x_base, y_base: cmd_y_base,
                      scale: cmd_scale_fp16, z_x: cmd_z_x, z_w: cmd_z_w, zero: cmd_zero};
          r_d     = '0;
          state_d = (cmd_rows == '0) ? S_DONE : S_XREQ;
        end
      end
      S_XREQ:  state_d = S_XWAIT;
      S_XWAIT: state_d = S_START;
      S_START: state_d = S_RUN;
      S_RUN:   if (mm_out_valid) state_d = S_WRITE;
      S_WRITE: begin
        r_d     = r_q + ROWS_W'(1);
        state_d = (r_d == cmd_q.rows) ? S_DONE : S_START;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs, decoded from the upcoming state so they line up with it.
  always_comb begin
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    mm_start_d  = (state_d == S_START);
    y_wr_en_d   = (state_d == S_WRITE);
    x_rd_en_d   = 1'b0;
    x_rd_addr_d = x_rd_addr_q;
    y_wr_addr_d = y_wr_addr_q;
    cap_d       = x_rd_en_q;
    mm_x_d      = cap_q ? x_rd_data : mm_x_q;
    if (state_d == S_XREQ) begin
      x_rd_en_d   = 1'b1;
      x_rd_addr_d = cmd_d.x_base;
    end
    // Prefetch next row on the first RUN cycle; StMM already holds the current X.
    if ((state_q == S_START) && ((r_q + ROWS_W'(1)) < cmd_q.rows)) begin
      x_rd_en_d   = 1'b1;
      x_rd_addr_d = cmd_q.x_base + XAW'(r_q) + XAW'(1);
    end
    if (state_d == S_WRITE) begin
      y_wr_addr_d = cmd_q.y_base + YAW'(r_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      x_rd_en_q   <= 1'b0;
      x_rd_addr_q <= '0;
      cap_q       <= 1'b0;
      mm_x_q      <= '0;
      mm_start_q  <= 1'b0;
      y_wr_en_q   <= 1'b0;
      y_wr_addr_q <= '0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      x_rd_en_q   <= x_rd_en_d;
      x_rd_addr_q <= x_rd_addr_d;
      cap_q       <= cap_d;
      mm_x_q      <= mm_x_d;
      mm_start_q  <= mm_start_d;
      y_wr_en_q   <= y_wr_en_d;
      y_wr_addr_q <= y_wr_addr_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign x_rd_en       = x_rd_en_q;
  assign x_rd_addr     = x_rd_addr_q;
  assign mm_x          = mm_x_q;
  assign mm_start      = mm_start_q;
  assign y_wr_en       = y_wr_en_q;
  assign y_wr_addr     = y_wr_addr_q;
  assign y_wr_data     = mm_y;
  assign mm_scale_fp16 = cmd_q.scale;
  assign mm_z_x        = cmd_q.z_x;
  assign mm_z_w        = cmd_q.z_w;
  assign mm_zero       = cmd_q.zero;

`ifdef STMM_SEQ_PERF_EN
  stmm_seq_perf_cnt #(.W(PERF_W)) u_perf_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (busy_q),
    .count (perf_cycles)
  );
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_stmm_seq.sv
// Directed bench for stmm_seq with behavioural X buffer and StMM latency model.
module tb_stmm_seq;
  import tinynpu_stmm_pkg::*;

  localparam int unsigned TN = 4;
  localparam int unsigned TP = 2;
  localparam int unsigned TQ = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ROWS_W-1:0] cmd_rows;
  logic [XAW-1:0]    cmd_x_base;
  logic [YAW-1:0]    cmd_y_base;
  logic [15:0]       cmd_scale_fp16;
  logic [7:0]        cmd_z_x, cmd_z_w, cmd_zero;
  logic              x_rd_en;
  logic [XAW-1:0]    x_rd_addr;
  logic [TQ*TN-1:0]  x_rd_data;
  logic [TQ*TN-1:0]  mm_x;
  logic              mm_start;
  logic [15:0]       mm_scale_fp16;
  logic [7:0]        mm_z_x, mm_z_w, mm_zero;
  logic [TQ*TP-1:0]  mm_y;
  logic              mm_out_valid;
  logic              y_wr_en;
  logic [YAW-1:0]    y_wr_addr;
  logic [TQ*TP-1:0]  y_wr_data;
  logic              busy;
  logic              done;
`ifdef STMM_SEQ_PERF_EN
  logic [PERF_W-1:0] perf_cycles;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int lat    = 20;

  always #5 clk = ~clk;

  stmm_seq #(.N(TN), .P(TP), .Q(TQ)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rows(cmd_rows), .cmd_x_base(cmd_x_base), .cmd_y_base(cmd_y_base),
    .cmd_scale_fp16(cmd_scale_fp16), .cmd_z_x(cmd_z_x), .cmd_z_w(cmd_z_w), .cmd_zero(cmd_zero),
    .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr), .x_rd_data(x_rd_data),
    .mm_x(mm_x), .mm_start(mm_start), .mm_scale_fp16(mm_scale_fp16),
    .mm_z_x(mm_z_x), .mm_z_w(mm_z_w), .mm_zero(mm_zero),
    .mm_y(mm_y), .mm_out_valid(mm_out_valid),
    .y_wr_en(y_wr_en), .y_wr_addr(y_wr_addr), .y_wr_data(y_wr_data),
    .busy(busy),
`ifdef STMM_SEQ_PERF_EN
    .done(done), .perf_cycles(perf_cycles)
`else
    .done(done)
`endif
  );

  function automatic logic [TQ*TN-1:0] xdata(input logic [XAW-1:0] a);
    logic [7:0] b;
    b = a[7:0] ^ 8'hA5;
    return {b, b + 8'd1, b + 8'd2, {6'd0, a[9:8]}};
  endfunction

  function automatic logic [TQ*TP-1:0] ydata(input logic [TQ*TN-1:0] x);
    return {x[31:24] ^ 8'h3C, x[7:0] + x[23:16]};
  endfunction

  // X buffer: one-cycle read latency.
  always @(posedge clk) begin
    if (x_rd_en) x_rd_data <= xdata(x_rd_addr);
  end

  // StMM model: latches X at start, raises out_valid lat cycles after the start cycle.
  int               mm_cnt;
  logic [TQ*TN-1:0] mm_xl;
  always @(posedge clk) begin
    if (rst) begin
      mm_cnt       <= 0;
      mm_out_valid <= 1'b0;
      mm_y         <= '0;
    end else if (mm_start) begin
      mm_cnt       <= lat - 1;
      mm_xl        <= mm_x;
      mm_out_valid <= 1'b0;
    end else if (mm_cnt > 1) begin
      mm_cnt <= mm_cnt - 1;
    end else if (mm_cnt == 1) begin
      mm_cnt       <= 0;
      mm_out_valid <= 1'b1;
      mm_y         <= ydata(mm_xl);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int             rows;
    logic [XAW-1:0] xb;
    logic [YAW-1:0] yb;
    logic [15:0]    scale;
    int             lat;
    bit             hold;
    int             exp_done;
    int             exp_first_rd;
    int             exp_first_st;
    logic [XAW-1:0] exp_rd_last;
    logic [YAW-1:0] exp_wr_last;
  } vec_t;

  // Drive one command from the #1 phase; cycle T is the cycle whose ending edge accepts it.
  task automatic run_cmd(input vec_t v);
    int n_rd = 0, n_st = 0, n_wr = 0, n_done = 0, y_bad = 0, wa_bad = 0;
    int done_cyc = -1, ready_cyc = -1, first_rd = 0, first_st = 0;
    logic [XAW-1:0] rd_last = '0;
    logic [YAW-1:0] wr_last = '0;
    lat            = v.lat;
    cmd_rows       = ROWS_W'(v.rows);
    cmd_x_base     = v.xb;
    cmd_y_base     = v.yb;
    cmd_scale_fp16 = v.scale;
    cmd_z_x        = v.scale[7:0];
    cmd_z_w        = v.scale[15:8];
    cmd_zero       = v.scale[7:0] ^ 8'hFF;
    cmd_valid      = 1'b1;
    @(posedge clk); #1;
    if (v.hold) begin
      cmd_rows       = ROWS_W'(5);
      cmd_scale_fp16 = 16'hBEEF;
    end else begin
      cmd_valid = 1'b0;
    end
    for (int k = 1; k <= v.exp_done + 10; k++) begin
      if (x_rd_en) begin
        n_rd++;
        rd_last = x_rd_addr;
        if (first_rd == 0) first_rd = k;
      end
      if (mm_start) begin
        n_st++;
        if (first_st == 0) first_st = k;
      end
      if (y_wr_en) begin
        if (y_wr_addr !== v.yb + YAW'(n_wr)) wa_bad++;
        if (y_wr_data !== ydata(xdata(v.xb + XAW'(n_wr)))) y_bad++;
        wr_last = y_wr_addr;
        n_wr++;
      end
      if (done) begin
        n_done++;
        done_cyc = k;
      end
      if (cmd_ready) begin
        ready_cyc = k;
        break;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    chk("done_cycle", 64'(done_cyc), 64'(v.exp_done));
    chk("ready_cycle", 64'(ready_cyc), 64'(v.exp_done + 1));
    chk("done_pulses", 64'(n_done), 64'd1);
    chk("x_reads", 64'(n_rd), 64'(v.rows));
    chk("mm_starts", 64'(n_st), 64'(v.rows));
    chk("y_writes", 64'(n_wr), 64'(v.rows));
    chk("first_rd_cycle", 64'(first_rd), 64'(v.exp_first_rd));
    chk("first_start_cycle", 64'(first_st), 64'(v.exp_first_st));
    chk("last_rd_addr", 64'(rd_last), 64'(v.exp_rd_last));
    chk("last_wr_addr", 64'(wr_last), 64'(v.exp_wr_last));
    chk("wr_addr_seq_errs", 64'(wa_bad), 64'd0);
    chk("y_data_errs", 64'(y_bad), 64'd0);
    chk("mm_scale_latched", 64'(mm_scale_fp16), 64'(v.scale));
    chk("mm_zero_latched", 64'(mm_zero), 64'(v.scale[7:0] ^ 8'hFF));
`ifdef STMM_SEQ_PERF_EN
    chk("perf_cycles", 64'(perf_cycles), 64'(v.exp_done));
    repeat (3) @(posedge clk);
    #1;
    chk("perf_cycles_held", 64'(perf_cycles), 64'(v.exp_done));
`else
    @(posedge clk); #1;
`endif
  endtask

  vec_t vecs[4];
  int   st_seen;

  initial begin
    // Expected done cycle = 2 + rows*(lat+2) + 1 after accept; rows=0 gives 1.
    vecs[0] = '{rows:3, xb:10'h010, yb:10'h020, scale:16'h3C00, lat:20, hold:1'b0,
                exp_done:69, exp_first_rd:1, exp_first_st:3, exp_rd_last:10'h012, exp_wr_last:10'h022};
    vecs[1] = '{rows:0, xb:10'h055, yb:10'h066, scale:16'h1234, lat:20, hold:1'b0,
                exp_done:1, exp_first_rd:0, exp_first_st:0, exp_rd_last:10'h000, exp_wr_last:10'h000};
    vecs[2] = '{rows:2, xb:10'h3FF, yb:10'h3FF, scale:16'h4000, lat:5, hold:1'b1,
                exp_done:17, exp_first_rd:1, exp_first_st:3, exp_rd_last:10'h000, exp_wr_last:10'h000};
    vecs[3] = '{rows:1, xb:10'h100, yb:10'h200, scale:16'h2A5A, lat:10, hold:1'b0,
                exp_done:15, exp_first_rd:1, exp_first_st:3, exp_rd_last:10'h100, exp_wr_last:10'h200};

    rst = 1'b1; cmd_valid = 1'b0; cmd_rows = '0; cmd_x_base = '0; cmd_y_base = '0;
    cmd_scale_fp16 = '0; cmd_z_x = '0; cmd_z_w = '0; cmd_zero = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_ctrl_zero", 64'({busy, done, x_rd_en, mm_start, y_wr_en}), 64'd0);
    chk("rst_data_zero", 64'({mm_x, x_rd_addr, y_wr_addr}), 64'd0);
    chk("rst_cfg_zero", 64'({mm_scale_fp16, mm_z_x, mm_z_w, mm_zero}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) run_cmd(vecs[i]);

    // Reset in RUN of row 1 of a 4-row command.
    lat = 8; cmd_rows = ROWS_W'(4); cmd_x_base = 10'h040; cmd_y_base = 10'h080;
    cmd_scale_fp16 = 16'h7777; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    st_seen = 0;
    for (int k = 0; k < 60 && st_seen < 2; k++) begin
      if (mm_start) st_seen++;
      if (st_seen < 2) begin
        @(posedge clk); #1;
      end
    end
    chk("mid_rst_second_start", 64'(st_seen), 64'd2);
    @(posedge clk); #1;
    chk("mid_rst_in_run_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("mid_rst_ctrl_zero", 64'({busy, done, x_rd_en, mm_start, y_wr_en}), 64'd0);
    chk("mid_rst_data_zero", 64'({mm_x, x_rd_addr, y_wr_addr}), 64'd0);
    chk("mid_rst_cfg_zero", 64'({mm_scale_fp16, mm_z_x, mm_z_w, mm_zero}), 64'd0);
    run_cmd(vecs[3]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
